// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error/break handling.
// Optional `UART_RX_MAJORITY_EN enables 2-of-3 voting around every sample point (needs CLKS_PER_BIT >= 6).
module uart_rx_framed #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam int unsigned H       = (CLKS_PER_BIT - 1) / 2;
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // Start decision one clock late so the vote window is centred; later bit-ends inherit the shift.
    localparam logic [15:0] START_END = 16'(H + 1);
`else
    localparam logic [15:0] START_END = 16'(H);
`endif

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_CLEANUP    = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  byte_q;
    logic        dv_q;
    logic        err_q;
    logic        active_q;
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        sample_s;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // History of the two previous synchronized samples for the vote
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_hist_q <= 2'b11;
        end else begin
            rx_hist_q <= {rx_hist_q[0], rx_sync_q};
        end
    end

    // Voted sample: counter values target-1, target, target+1
    always_comb begin
        sample_s = maj3(rx_hist_q[1], rx_hist_q[0], rx_sync_q);
    end
`else
    // Single sample at the target count
    always_comb begin
        sample_s = rx_sync_q;
    end
`endif

    // Receive FSM with registered outputs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            byte_q   <= 8'h00;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 16'd0;
                    idx_q <= 3'd0;
                    if (!rx_sync_q) begin
                        state_q  <= ST_START;
                        active_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == START_END) begin
                        cnt_q <= 16'd0;
                        if (!sample_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q  <= ST_IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q          <= 16'd0;
                        shift_q[idx_q] <= sample_s;
                        if (idx_q == 3'd7) begin
                            idx_q   <= 3'd0;
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q  <= 16'd0;
                        byte_q <= shift_q;
                        if (sample_s) begin
                            dv_q    <= 1'b1;
                            state_q <= ST_CLEANUP;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_BREAK_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_CLEANUP: begin
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_BREAK_WAIT: begin
                    // A held-low line must not be decoded as a stream of 8'h00 frames
                    if (rx_sync_q) begin
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= 16'd0;
                    idx_q    <= 3'd0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Frame_Err = err_q;
    assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: serial frames built from bit lists, compared to a byte/latency model.
module tb_uart_rx_framed;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       dv;
    logic [7:0] rbyte;
    logic       ferr;
    logic       active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int         dv_cyc[$];
    logic [7:0] dv_byte[$];
    int         err_cyc[$];
    bit         overlap = 1'b0;

    uart_rx_framed #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Rx_Serial   (rx),
        .o_Rx_DV       (dv),
        .o_Rx_Byte     (rbyte),
        .o_Rx_Frame_Err(ferr),
        .o_Rx_Active   (active)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the inactive edge
    always @(negedge clk) begin
        cyc++;
        if (dv === 1'b1) begin
            dv_cyc.push_back(cyc);
            dv_byte.push_back(rbyte);
        end
        if (ferr === 1'b1) err_cyc.push_back(cyc);
        if (dv === 1'b1 && ferr === 1'b1) overlap = 1'b1;
    end

    task automatic clear_mon();
        dv_cyc.delete();
        dv_byte.delete();
        err_cyc.delete();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clks(CPB);
    endtask

    // Line-level model: a frame is start(0), 8 data bits LSB first, stop
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(bits[i]);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dv); end
        checks++; if (rbyte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", rbyte); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ferr); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
        rst_n = 1'b1;
        wait_clks(2 * CPB);
    endtask

    task automatic test_clean();
        int t0, lat, exp_lat;
        clear_mon();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_clks(4);
        exp_lat = 9 * CPB + H + 4 + MAJ;
        checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL clean_dv_count got %0d want 1", dv_cyc.size()); end
        checks++; if (err_cyc.size() != 0) begin errors++; $display("FAIL clean_err_count got %0d want 0", err_cyc.size()); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL clean_active got %b want 0", active); end
        if (dv_cyc.size() > 0) begin
            lat = dv_cyc[0] - t0 - 1;
            checks++; if (dv_byte[0] !== 8'hA5) begin errors++; $display("FAIL clean_byte got %h want a5", dv_byte[0]); end
            checks++; if (lat < exp_lat - 1 || lat > exp_lat + 1) begin errors++; $display("FAIL clean_latency got %0d want %0d+/-1", lat, exp_lat); end
        end
        wait_clks(CPB);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        clear_mon();
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
        wait_clks(2 * CPB);
        checks++; if (dv_cyc.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", dv_cyc.size()); end
        if (dv_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (dv_byte[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, dv_byte[i], exp_q[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (dv_cyc[i] - dv_cyc[i-1] != 10 * CPB) begin errors++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, dv_cyc[i] - dv_cyc[i-1], 10 * CPB); end
            end
        end
    endtask

    task automatic test_break();
        clear_mon();
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        wait_clks(40 * CPB);
        checks++; if (err_cyc.size() != 1) begin errors++; $display("FAIL break_err_count got %0d want 1", err_cyc.size()); end
        checks++; if (dv_cyc.size() != 0) begin errors++; $display("FAIL break_dv_count got %0d want 0", dv_cyc.size()); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL break_active_low got %b want 1", active); end
        rx = 1'b1;
        wait_clks(6);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL break_active_release got %b want 0", active); end
        wait_clks(2 * CPB);
        checks++; if (dv_cyc.size() != 0 || err_cyc.size() != 1) begin errors++; $display("FAIL break_after got dv=%0d err=%0d want 0/1", dv_cyc.size(), err_cyc.size()); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(13);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL glitch_active got %b want 0", active); end
        wait_clks(11 * CPB);
        checks++; if (dv_cyc.size() != 0 || err_cyc.size() != 0) begin errors++; $display("FAIL glitch_pulses got dv=%0d err=%0d want 0/0", dv_cyc.size(), err_cyc.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        bits = {1'b1, 8'hC3, 1'b0};
        clear_mon();
        for (int i = 0; i < 5; i++) drive_bit(bits[i]);
        rx = bits[5];
        wait_clks(CPB / 2);
        rst_n = 1'b0;
        wait_clks(2);
        checks++; if (dv !== 1'b0 || ferr !== 1'b0 || active !== 1'b0 || rbyte !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs got dv=%b err=%b act=%b byte=%h want 0/0/0/00", dv, ferr, active, rbyte);
        end
        rst_n = 1'b1;
        rx = 1'b1;
        wait_clks(12 * CPB);
        checks++; if (dv_cyc.size() != 0 || err_cyc.size() != 0) begin errors++; $display("FAIL midrst_aborted got dv=%0d err=%0d want 0/0", dv_cyc.size(), err_cyc.size()); end
        send_frame(8'h81, 1'b1);
        wait_clks(4);
        checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL midrst_dv_count got %0d want 1", dv_cyc.size()); end
        else begin
            checks++; if (dv_byte[0] !== 8'h81) begin errors++; $display("FAIL midrst_byte got %h want 81", dv_byte[0]); end
        end
        wait_clks(CPB);
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int gap;
        clear_mon();
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            gap = $urandom_range(0, 3);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            wait_clks(gap * CPB + $urandom_range(0, 5));
        end
        wait_clks(2 * CPB);
        checks++; if (dv_byte.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", dv_byte.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                checks++; if (dv_byte[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, dv_byte[i], exp_q[i]); end
            end
        end
    endtask

    // One-clock inverted spike in the middle of every data bit
    task automatic test_spike();
        logic [7:0] b;
        logic [7:0] want;
        b = 8'h96;
        want = (MAJ == 1) ? 8'h96 : 8'h69;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB / 2);
            rx = ~b[i];
            wait_clks(1);
            rx = b[i];
            wait_clks(CPB / 2 - 1);
        end
        drive_bit(1'b1);
        wait_clks(4);
        checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL spike_dv_count got %0d want 1", dv_cyc.size()); end
        else begin
            checks++; if (dv_byte[0] !== want) begin errors++; $display("FAIL spike_byte got %h want %h", dv_byte[0], want); end
        end
        wait_clks(CPB);
    endtask

    initial begin
        wait_clks(1);
        test_reset();
        test_clean();
        test_back_to_back();
        test_break();
        test_glitch();
        test_reset_midframe();
        test_random();
        test_spike();
        checks++; if (overlap) begin errors++; $display("FAIL dv_err_overlap got 1 want 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
